div3_serial_tx: RTL and testbench



---
 rtl/div3_pkg.sv | 45 ++++
 rtl/div3_rem_step.sv | 63 ++++++
 rtl/div3_serial_tx.sv | 139 +++++++++++++
 tb/tb_div3_serial_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div3_pkg.sv
// ============================================================================
// Module      : div3_pkg
// Description : Shared types and helpers for the serial divisible-by-3
//               transmitter: remainder encoding, next-remainder function and
//               quotient-bit function. The optional quotient output of the
//               transmitter is enabled by defining DIV3_QUOTIENT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package div3_pkg;

  // Remainder of the prefix received so far, modulo 3. Encoding 3 is unused.
  typedef enum logic [1:0] {
    REM_0 = 2'd0,
    REM_1 = 2'd1,
    REM_2 = 2'd2
  } rem_t;

  // Appending bit x to a prefix with remainder r gives (2*r + x) mod 3.
  // The unused encoding behaves like REM_0 so a corrupted register recovers.
  function automatic rem_t next_rem(input rem_t r, input logic x);
    rem_t n;
    case (r)
      REM_1:   n = x ? REM_0 : REM_2;
      REM_2:   n = x ? REM_2 : REM_1;
      default: n = x ? REM_1 : REM_0;
    endcase
    return n;
  endfunction

  // Quotient bit produced by the same step: 1 when (2*r + x) >= 3.
  function automatic logic quot_bit(input rem_t r, input logic x);
    logic q;
    case (r)
      REM_1:   q = x;
      REM_2:   q = 1'b1;
      default: q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div3_rem_step.sv
// ============================================================================
// Module      : div3_rem_step
// Description : Running mod-3 remainder register. rem_o is the remainder of
//               the prefix including bit_i (combinational look-ahead); the
//               register commits it on advance and returns to REM_0 on clear.
//               With DIV3_QUOTIENT_EN defined, q_o carries the matching
//               quotient bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div3_rem_step
  import div3_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  input  logic       bit_i,
  output logic [1:0] rem_o
`ifdef DIV3_QUOTIENT_EN
  ,
  output logic       q_o
`endif
);

  rem_t rem_q;
  rem_t rem_d;

  // Next remainder: clear wins over advance so a new frame always restarts.
  always_comb begin
    rem_d = rem_q;
    if (clear) begin
      rem_d = REM_0;
    end else if (advance) begin
      rem_d = next_rem(rem_q, bit_i);
    end
  end

  // Remainder register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= REM_0;
    end else begin
      rem_q <= rem_d;
    end
  end

  // Look-ahead remainder including the bit currently presented.
  always_comb begin
    rem_o = next_rem(rem_q, bit_i);
  end

`ifdef DIV3_QUOTIENT_EN
  // Quotient bit of the same step.
  always_comb begin
    q_o = quot_bit(rem_q, bit_i);
  end
`endif

endmodule

`default_nettype wire

// File: rtl/div3_serial_tx.sv
// ============================================================================
// Module      : div3_serial_tx
// Description : Parallel-to-serial transmitter, MSB first, with valid/ready
//               on both sides. Each serial bit is accompanied by the mod-3
//               remainder and divisibility verdict of the prefix sent so far.
//               Defining DIV3_QUOTIENT_EN adds the quotient-bit output q_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div3_serial_tx
  import div3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             x_o,
  output logic             x_valid_o,
  input  logic             x_ready_i,
  output logic             last_o,
  output logic             div_o,
  output logic [1:0]       rem_o
`ifdef DIV3_QUOTIENT_EN
  ,
  output logic             q_o
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic       w_accept;
  logic       w_bit_xfer;
  logic       w_clear;
  logic       w_advance;
  logic [1:0] w_rem;
`ifdef DIV3_QUOTIENT_EN
  logic       w_q;
`endif

  assign w_accept   = in_valid_i && in_ready_o;
  assign w_bit_xfer = x_valid_o && x_ready_i;
  // A new word or the last bit of a frame restarts the remainder.
  assign w_clear    = w_accept || (w_bit_xfer && last_o);
  assign w_advance  = w_bit_xfer && !last_o;

  // State, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a word accepted on the last bit keeps SHIFT with no bubble.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        if (w_bit_xfer && last_o && !w_accept) begin
          state_d = S_IDLE;
        end
      end
    endcase
    if (w_accept) begin
      shreg_d = data_i;
      cnt_d   = CNT_W'(WIDTH - 1);
    end else if (w_advance) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      cnt_d   = cnt_q - 1'b1;
    end
  end

  // Handshake and serial outputs decoded from the state.
  always_comb begin
    in_ready_o = 1'b1;
    x_valid_o  = 1'b0;
    x_o        = 1'b0;
    last_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
      end
      default: begin
        x_valid_o  = 1'b1;
        x_o        = shreg_q[WIDTH-1];
        last_o     = (cnt_q == '0);
        in_ready_o = (cnt_q == '0) && x_ready_i;
      end
    endcase
  end

  div3_rem_step u_rem_step (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_clear),
    .advance (w_advance),
    .bit_i   (x_o),
    .rem_o   (w_rem)
`ifdef DIV3_QUOTIENT_EN
    ,
    .q_o     (w_q)
`endif
  );

  // Verdict outputs are only meaningful alongside a valid bit.
  always_comb begin
    rem_o = x_valid_o ? w_rem : 2'd0;
    div_o = x_valid_o && (rem_o == 2'd0);
`ifdef DIV3_QUOTIENT_EN
    q_o   = x_valid_o && w_q;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_div3_serial_tx.sv
// ============================================================================
// Module      : tb_div3_serial_tx
// Description : Directed bench for div3_serial_tx (WIDTH=4 instance) plus a
//               randomised frame loop on a WIDTH=8 instance. q_o is checked
//               when DIV3_QUOTIENT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div3_serial_tx;

`ifdef DIV3_QUOTIENT_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       a_in_valid, a_in_ready, a_x, a_x_valid, a_x_ready, a_last, a_div, a_q;
  logic [3:0] a_data;
  logic [1:0] a_rem;

  logic       b_in_valid, b_in_ready, b_x, b_x_valid, b_x_ready, b_last, b_div, b_q;
  logic [7:0] b_data;
  logic [1:0] b_rem;

`ifndef DIV3_QUOTIENT_EN
  assign a_q = 1'b0;
  assign b_q = 1'b0;
`endif

  div3_serial_tx #(.WIDTH(4)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (a_in_valid),
    .in_ready_o (a_in_ready),
    .data_i     (a_data),
    .x_o        (a_x),
    .x_valid_o  (a_x_valid),
    .x_ready_i  (a_x_ready),
    .last_o     (a_last),
    .div_o      (a_div),
    .rem_o      (a_rem)
`ifdef DIV3_QUOTIENT_EN
    ,
    .q_o        (a_q)
`endif
  );

  div3_serial_tx #(.WIDTH(8)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (b_in_valid),
    .in_ready_o (b_in_ready),
    .data_i     (b_data),
    .x_o        (b_x),
    .x_valid_o  (b_x_valid),
    .x_ready_i  (b_x_ready),
    .last_o     (b_last),
    .div_o      (b_div),
    .rem_o      (b_rem)
`ifdef DIV3_QUOTIENT_EN
    ,
    .q_o        (b_q)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] got;
    reset      = 1'b1;
    a_in_valid = 1'b0; a_data = 4'h0; a_x_ready = 1'b0;
    b_in_valid = 1'b0; b_data = 8'h0; b_x_ready = 1'b0;
    tick; tick;
    reset = 1'b0;
    #1;
    got = {a_in_ready, a_x_valid, a_x, a_last, a_div, a_rem, a_q};
    n_checks++;
    if (got !== 8'b1000_0000) $display("FAIL reset_a: got %b expected %b", got, 8'b1000_0000);
    else n_pass++;
    got = {b_in_ready, b_x_valid, b_x, b_last, b_div, b_rem, b_q};
    n_checks++;
    if (got !== 8'b1000_0000) $display("FAIL reset_b: got %b expected %b", got, 8'b1000_0000);
    else n_pass++;
    tick;
  endtask

  // One WIDTH=4 frame with x_ready_i held high; tables list bit 3 first.
  task automatic test_frame(input string name, input logic [3:0] d,
                            input logic [3:0] ex_div, input logic [7:0] ex_rem,
                            input logic [3:0] ex_q);
    logic [7:0] got, exp;
    a_in_valid = 1'b1; a_data = d; a_x_ready = 1'b1;
    tick;
    a_in_valid = 1'b0; a_data = 4'($urandom);
    for (int k = 0; k < 4; k++) begin
      #1;
      got = {a_in_ready, a_x_valid, a_x, a_last, a_div, a_rem, a_q};
      exp = {(k == 3), 1'b1, d[3-k], (k == 3), ex_div[3-k], ex_rem[7-2*k -: 2], QEN & ex_q[3-k]};
      n_checks++;
      if (got !== exp) $display("FAIL %s bit%0d: got %b expected %b", name, k, got, exp);
      else n_pass++;
      tick;
    end
    #1;
    n_checks++;
    if ({a_in_ready, a_x_valid} !== 2'b10)
      $display("FAIL %s idle: got %b expected 10", name, {a_in_ready, a_x_valid});
    else n_pass++;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [7:0]  x_seq   = 8'b1111_0101;
    logic [7:0]  div_seq = 8'b0101_1000;
    logic [15:0] rem_seq = 16'b01_00_01_00_00_01_10_10;
    logic [7:0]  q_seq   = 8'b0101_0001;
    logic [7:0]  got, exp;
    a_in_valid = 1'b1; a_data = 4'd15; a_x_ready = 1'b1;
    tick;
    a_data = 4'd5;
    for (int k = 0; k < 8; k++) begin
      #1;
      got = {a_in_ready, a_x_valid, a_x, a_last, a_div, a_rem, a_q};
      exp = {(k == 3) || (k == 7), 1'b1, x_seq[7-k], (k == 3) || (k == 7),
             div_seq[7-k], rem_seq[15-2*k -: 2], QEN & q_seq[7-k]};
      if (k == 7) exp[7] = 1'b1;
      n_checks++;
      if (got !== exp) $display("FAIL b2b bit%0d: got %b expected %b", k, got, exp);
      else n_pass++;
      if (k == 4) a_in_valid = 1'b0;
      tick;
    end
    #1;
    n_checks++;
    if ({a_in_ready, a_x_valid} !== 2'b10)
      $display("FAIL b2b idle: got %b expected 10", {a_in_ready, a_x_valid});
    else n_pass++;
    tick;
  endtask

  // data=9 (1001): rem 1,2,1,0; div 0,0,0,1; q 0,0,1,1. Stall on bit index 1.
  task automatic test_backpressure;
    logic [3:0] d       = 4'd9;
    logic [3:0] div_seq = 4'b0001;
    logic [7:0] rem_seq = 8'b01_10_01_00;
    logic [3:0] q_seq   = 4'b0011;
    logic [7:0] got, exp;
    a_in_valid = 1'b1; a_data = d; a_x_ready = 1'b1;
    tick;
    a_in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp = {(k == 3), 1'b1, d[3-k], (k == 3), div_seq[3-k], rem_seq[7-2*k -: 2], QEN & q_seq[3-k]};
      if (k == 1) begin
        a_x_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          got = {a_in_ready, a_x_valid, a_x, a_last, a_div, a_rem, a_q};
          n_checks++;
          if (got !== exp) $display("FAIL stall cyc%0d: got %b expected %b", s, got, exp);
          else n_pass++;
          tick;
        end
        a_x_ready = 1'b1;
      end
      #1;
      got = {a_in_ready, a_x_valid, a_x, a_last, a_div, a_rem, a_q};
      n_checks++;
      if (got !== exp) $display("FAIL bp bit%0d: got %b expected %b", k, got, exp);
      else n_pass++;
      tick;
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] got;
    a_in_valid = 1'b1; a_data = 4'b1010; a_x_ready = 1'b1;
    tick;
    a_in_valid = 1'b0;
    tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    got = {a_in_ready, a_x_valid, a_x, a_last, a_div, a_rem, a_q};
    n_checks++;
    if (got !== 8'b1000_0000) $display("FAIL mid_reset: got %b expected %b", got, 8'b1000_0000);
    else n_pass++;
    tick;
    // data=3 (0011): rem 0,0,1,0; div 1,1,0,1; q 0,0,0,1.
    test_frame("after_reset_3", 4'd3, 4'b1101, 8'b00_00_01_00, 4'b0001);
  endtask

  task automatic test_random;
    logic [7:0] d, prefix, qacc;
    logic [1:0] r;
    logic [5:0] got, exp;
    int k, cyc;
    for (int f = 0; f < 1000; f++) begin
      d = 8'($urandom);
      b_in_valid = 1'b1; b_data = d; b_x_ready = 1'b0;
      #1;
      n_checks++;
      if ({b_in_ready, b_x_valid} !== 2'b10)
        $display("FAIL rand_idle f%0d: got %b expected 10", f, {b_in_ready, b_x_valid});
      else n_pass++;
      tick;
      b_in_valid = 1'b0; b_data = 8'($urandom);
      k = 0; cyc = 0; qacc = 8'h0;
      while (k < 8 && cyc < 64) begin
        b_x_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (b_x_ready) begin
          prefix = d >> (7 - k);
          r      = 2'(prefix % 8'd3);
          got    = {b_x_valid, b_x, b_last, b_div, b_rem};
          exp    = {1'b1, d[7-k], (k == 7), (r == 2'd0), r};
          n_checks++;
          if (got !== exp) $display("FAIL rand f%0d d=%0d bit%0d: got %b expected %b", f, d, k, got, exp);
          else n_pass++;
          qacc = {qacc[6:0], b_q};
          k++;
        end
        tick;
        cyc++;
      end
      if (k < 8) begin
        n_checks++;
        $display("FAIL rand_timeout f%0d: got %0d bits expected 8", f, k);
      end
`ifdef DIV3_QUOTIENT_EN
      n_checks++;
      if (qacc !== d / 8'd3) $display("FAIL rand_quot f%0d: got %0d expected %0d", f, qacc, d / 8'd3);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset;
    // data=6 (0110): rem 0,1,0,0; div 1,0,1,1; q 0,0,1,0.
    test_frame("data6", 4'd6, 4'b1011, 8'b00_01_00_00, 4'b0010);
    // data=7 (0111): rem 0,1,0,1; div 1,0,1,0; q 0,0,1,0.
    test_frame("data7", 4'd7, 4'b1010, 8'b00_01_00_01, 4'b0010);
    test_back_to_back;
    test_backpressure;
    test_reset_mid_frame;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
